// File: rtl/hpdl_pkg.sv
`default_nettype none
// ==== hpdl_pkg : shared state type and character constants for the HPDL-1414 scan driver ====
// ==== Revision 1.0                                                                      ====
package hpdl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } scan_state_t;

  localparam int DISPLAY_COUNT      = 4;
  localparam int DIGITS_PER_DISPLAY = 4;
  localparam int BUFFER_DEPTH       = 16;

  localparam logic [7:0] CARETCHR = 8'h5F;
  localparam logic [7:0] SPACECHR = 8'h20;
  localparam logic [7:0] HPDL_MIN = 8'h20;
  localparam logic [7:0] HPDL_MAX = 8'h5F;

  localparam logic [7:0] LOWER_A     = 8'h61;
  localparam logic [7:0] LOWER_Z     = 8'h7A;
  localparam logic [6:0] CASE_OFFSET = 7'h20;

endpackage
`default_nettype wire

// File: rtl/hpdl_char_map.sv
`default_nettype none
// ==== hpdl_char_map : folds an 8-bit code onto the HPDL-1414 7-bit character set ====
// ==== Revision 1.0                                                               ====
module hpdl_char_map
  import hpdl_pkg::*;
(
  input  logic [7:0] char_in,
  output logic [6:0] char_out
);

  // Lower case is folded to upper case; anything the display cannot render shows as a blank.
  always_comb begin
    char_out = SPACECHR[6:0];
    if (char_in >= HPDL_MIN && char_in <= HPDL_MAX) begin
      char_out = char_in[6:0];
    end else if (char_in >= LOWER_A && char_in <= LOWER_Z) begin
      char_out = char_in[6:0] - CASE_OFFSET;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpdl1414_scan_driver.sv
`default_nettype none
// ==== hpdl1414_scan_driver : refreshes four HPDL-1414 displays from a 16-entry buffer ====
// ==== Revision 1.0                                                                   ====
module hpdl1414_scan_driver
  import hpdl_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int WR_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int REFRESH_DIV  = 120000,
  parameter int BLINK_DIV    = 3000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  output logic                     o_read_enable,
  output logic [3:0]               o_read_address,
  input  logic [7:0]               i_read_data,
  output logic                     o_caret_strobe,
  output logic [6:0]               o_hpdl_data,
  output logic [1:0]               o_hpdl_addr,
  output logic [DISPLAY_COUNT-1:0] o_hpdl_wr_n,
  output logic                     o_frame_done
);

  localparam int PHASE_MAX = (SETUP_CYCLES > WR_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((WR_CYCLES > HOLD_CYCLES) ? WR_CYCLES : HOLD_CYCLES);
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int REFRESH_W = $clog2(REFRESH_DIV + 1);
  localparam int BLINK_W   = $clog2(BLINK_DIV + 1);

  localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] WR_LAST    = PHASE_W'(WR_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]         LAST_IDX   = 4'(BUFFER_DEPTH - 1);
  localparam logic [1:0]         LAST_DIGIT = 2'(DIGITS_PER_DISPLAY - 1);

  scan_state_t              state, next_state;
  logic [3:0]               idx, next_idx;
  logic [PHASE_W-1:0]       phase, next_phase;
  logic                     pending, next_pending;
  logic                     frame_end;
  logic [DISPLAY_COUNT-1:0] next_wr_n;
  logic [6:0]               mapped_char;
  logic [REFRESH_W-1:0]     refresh_cnt;
  logic                     refresh_tick;
  logic [BLINK_W-1:0]       blink_cnt;
  logic                     blink_tick;

  hpdl_char_map u_char_map (
    .char_in  (i_read_data),
    .char_out (mapped_char)
  );

  assign refresh_tick = (refresh_cnt == REFRESH_W'(REFRESH_DIV - 1));
  assign blink_tick   = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      refresh_cnt    <= '0;
      blink_cnt      <= '0;
      o_caret_strobe <= 1'b1;
    end else begin
      refresh_cnt <= refresh_tick ? '0 : refresh_cnt + REFRESH_W'(1);
      blink_cnt   <= blink_tick ? '0 : blink_cnt + BLINK_W'(1);
      if (blink_tick) begin
        o_caret_strobe <= ~o_caret_strobe;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      idx     <= '0;
      phase   <= '0;
      pending <= 1'b1;
    end else begin
      state   <= next_state;
      idx     <= next_idx;
      phase   <= next_phase;
      pending <= next_pending;
    end
  end

  // A refresh tick landing in the same cycle a frame starts survives the clear.
  always_comb begin
    next_state   = state;
    next_idx     = idx;
    next_phase   = phase;
    next_pending = pending | refresh_tick;
    frame_end    = 1'b0;
    case (state)
      IDLE: begin
        if (pending && i_enable) begin
          next_state   = FETCH;
          next_idx     = '0;
          next_pending = refresh_tick;
        end
      end
      FETCH: next_state = WAIT;
      WAIT: begin
        next_state = SETUP;
        next_phase = '0;
      end
      SETUP: begin
        if (phase == SETUP_LAST) begin
          next_state = STROBE;
          next_phase = '0;
        end else begin
          next_phase = phase + PHASE_W'(1);
        end
      end
      STROBE: begin
        if (phase == WR_LAST) begin
          next_state = HOLD;
          next_phase = '0;
        end else begin
          next_phase = phase + PHASE_W'(1);
        end
      end
      HOLD: begin
        if (phase == HOLD_LAST) begin
          next_phase = '0;
          if (idx == LAST_IDX) begin
            next_state = IDLE;
            frame_end  = 1'b1;
          end else begin
            next_idx   = idx + 4'd1;
            next_state = i_enable ? FETCH : IDLE;
          end
        end else begin
          next_phase = phase + PHASE_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The strobe is registered so the display write lines never see decode glitches.
  always_comb begin
    next_wr_n = '1;
    if (next_state == STROBE) begin
      next_wr_n[next_idx[3:2]] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hpdl_wr_n  <= '1;
      o_hpdl_data  <= '0;
      o_hpdl_addr  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_hpdl_wr_n  <= next_wr_n;
      o_frame_done <= frame_end;
      if (state == WAIT) begin
        o_hpdl_data <= mapped_char;
        o_hpdl_addr <= LAST_DIGIT - idx[1:0];
      end
    end
  end

  assign o_read_enable  = (state == FETCH);
  assign o_read_address = idx;

endmodule
`default_nettype wire

// File: tb/tb_hpdl1414_scan_driver.sv
`default_nettype none
// ==== tb_hpdl1414_scan_driver : directed frames with random buffer contents vs a display model ====
// ==== Revision 1.0                                                                             ====
module tb_hpdl1414_scan_driver;

  localparam int BLINK   = 10;
  localparam int REFRESH = 50;
  localparam int CHAR_T  = 6;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       enable    = 1'b0;
  logic       read_enable;
  logic [3:0] read_address;
  logic [7:0] read_data = 8'h00;
  logic       caret_strobe;
  logic [6:0] hpdl_data;
  logic [1:0] hpdl_addr;
  logic [3:0] hpdl_wr_n;
  logic       frame_done;

  logic [7:0] mem [16];
  int edges = 0;
  int tests = 0;
  int fails = 0;

  int fetch_t[$];
  int fetch_a[$];
  int st_bit[$];
  int st_len[$];
  int st_data[$];
  int st_addr[$];
  int done_t;
  int unstable;
  int multi_low;
  int caret_bad;

  int map_exp[5] = '{'h41, 'h5A, 'h20, 'h20, 'h5F};

  hpdl1414_scan_driver #(
    .SETUP_CYCLES (1),
    .WR_CYCLES    (2),
    .HOLD_CYCLES  (1),
    .REFRESH_DIV  (REFRESH),
    .BLINK_DIV    (BLINK)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .o_read_enable  (read_enable),
    .o_read_address (read_address),
    .i_read_data    (read_data),
    .o_caret_strobe (caret_strobe),
    .o_hpdl_data    (hpdl_data),
    .o_hpdl_addr    (hpdl_addr),
    .o_hpdl_wr_n    (hpdl_wr_n),
    .o_frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release: the time base for blink and schedule expectations.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  // Synchronous-read display buffer.
  always @(posedge clk) begin
    if (read_enable) read_data <= mem[read_address];
  end

  function automatic int ref_map(input int c);
    if (c >= 32 && c <= 95)  return c;
    if (c >= 97 && c <= 122) return c - 32;
    return 32;
  endfunction

  function automatic int exp_caret(input int n);
    return ((n / BLINK) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int low_bit(input logic [3:0] w);
    for (int i = 0; i < 4; i++) if (w[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < 16; k++) mem[k] = 8'($urandom_range(0, 255));
  endtask

  // Observe the display bus cycle by cycle, collecting fetches and write strobes.
  task automatic capture(input int max_cycles, input bit stop_on_done);
    logic [3:0] prev_wr;
    logic [6:0] prev_data;
    logic [1:0] prev_addr;
    fetch_t.delete(); fetch_a.delete();
    st_bit.delete(); st_len.delete(); st_data.delete(); st_addr.delete();
    done_t = -1; unstable = 0; multi_low = 0; caret_bad = 0;
    prev_wr = hpdl_wr_n; prev_data = hpdl_data; prev_addr = hpdl_addr;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (int'(caret_strobe) != exp_caret(edges)) caret_bad++;
      if ($countones(~hpdl_wr_n) > 1) multi_low++;
      if (read_enable === 1'b1) begin
        fetch_t.push_back(edges);
        fetch_a.push_back(int'(read_address));
      end
      if (hpdl_wr_n != 4'hF) begin
        if (prev_wr == 4'hF) begin
          if (hpdl_data != prev_data || hpdl_addr != prev_addr) unstable++;
          st_bit.push_back(low_bit(hpdl_wr_n));
          st_len.push_back(1);
          st_data.push_back(int'(hpdl_data));
          st_addr.push_back(int'(hpdl_addr));
        end else begin
          st_len[st_len.size()-1] = st_len[st_len.size()-1] + 1;
          if (int'(hpdl_data) != st_data[st_data.size()-1] ||
              int'(hpdl_addr) != st_addr[st_addr.size()-1]) unstable++;
        end
      end else if (prev_wr != 4'hF) begin
        if (int'(hpdl_data) != st_data[st_data.size()-1] ||
            int'(hpdl_addr) != st_addr[st_addr.size()-1]) unstable++;
      end
      prev_wr = hpdl_wr_n; prev_data = hpdl_data; prev_addr = hpdl_addr;
      if (frame_done === 1'b1) begin
        done_t = edges;
        if (stop_on_done) break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int t_lo, input int t_hi);
    int t0;
    int bad_f;
    int bad_s;
    int bad_d;
    check({tag, ".fetch_count"}, fetch_t.size(), 16);
    check({tag, ".strobe_count"}, st_bit.size(), 16);
    t0 = (fetch_t.size() > 0) ? fetch_t[0] : -1;
    check({tag, ".first_fetch_in_window"}, int'(t0 >= t_lo && t0 <= t_hi), 1);
    bad_f = 0;
    for (int k = 0; k < fetch_t.size(); k++)
      if (fetch_a[k] != k || fetch_t[k] != t0 + CHAR_T * k) bad_f++;
    check({tag, ".fetch_schedule_errors"}, bad_f, 0);
    bad_s = 0;
    bad_d = 0;
    for (int k = 0; k < st_bit.size() && k < 16; k++) begin
      if (st_bit[k] != k / 4 || st_len[k] != 2 || st_addr[k] != 3 - (k % 4)) bad_s++;
      if (st_data[k] != ref_map(int'(mem[k]))) bad_d++;
    end
    check({tag, ".strobe_pattern_errors"}, bad_s, 0);
    check({tag, ".char_data_errors"}, bad_d, 0);
    check({tag, ".unstable_cycles"}, unstable, 0);
    check({tag, ".multi_low_cycles"}, multi_low, 0);
    check({tag, ".caret_errors"}, caret_bad, 0);
    check({tag, ".done_latency_ok"}, int'(done_t >= t0 + 95 && done_t <= t0 + 97), 1);
  endtask

  initial begin
    int  t;
    bit  found;

    for (int k = 0; k < 16; k++) mem[k] = 8'(8'h41 + k);
    enable = 1'b1;
    #1 rst = 1'b1;

    repeat (5) begin
      @(negedge clk);
      check("reset_outputs",
            int'({hpdl_wr_n, hpdl_data, hpdl_addr, read_enable, read_address, caret_strobe, frame_done}),
            int'({4'hF, 7'h00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0}));
    end
    rst = 1'b0;

    // Frame 1: ascending letters.
    capture(300, 1'b1);
    check_frame("alpha", 1, 2);
    check("alpha.pos5_addr", (st_addr.size() > 5) ? st_addr[5] : -1, 2);
    check("alpha.pos5_data", (st_data.size() > 5) ? st_data[5] : -1, 'h46);
    t = done_t;

    // Frame 2 follows straight on from the mid-frame refresh tick.
    mem[0] = 8'h61; mem[1] = 8'h7A; mem[2] = 8'h7F; mem[3] = 8'h10; mem[4] = 8'h5F;
    for (int k = 5; k < 16; k++) mem[k] = 8'($urandom_range(0, 255));
    capture(300, 1'b1);
    check_frame("mapping", t + 1, t + 1);
    for (int k = 0; k < 5; k++)
      check($sformatf("mapping.pos%0d", k), (st_data.size() > k) ? st_data[k] : -1, map_exp[k]);

    // Frame 3: drop enable during SETUP of position 3.
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (read_enable === 1'b1 && read_address == 4'd3) found = 1'b1;
    end
    check("drop.fetch3_seen", int'(found), 1);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    capture(60, 1'b0);
    check("drop.fetch_count", fetch_t.size(), 0);
    check("drop.strobe_count", st_bit.size(), 1);
    check("drop.no_frame_done", done_t, -1);
    if (st_bit.size() == 1) begin
      check("drop.strobe_bit", st_bit[0], 0);
      check("drop.strobe_addr", st_addr[0], 0);
      check("drop.strobe_len", st_len[0], 2);
      check("drop.strobe_data", st_data[0], ref_map(int'(mem[3])));
    end

    // Resume with pending set: fresh frame from position 0.
    randomize_mem();
    enable = 1'b1;
    t = edges;
    capture(300, 1'b1);
    check_frame("resume", t + 1, t + 2);

    // Reset while a write strobe is active.
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (hpdl_wr_n != 4'hF) found = 1'b1;
    end
    check("rst.strobe_seen", int'(found), 1);
    rst = 1'b1;
    #1;
    check("rst.wr_n_immediate", int'(hpdl_wr_n), 'hF);
    check("rst.read_port_idle", int'({read_enable, read_address}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    randomize_mem();
    capture(300, 1'b1);
    check_frame("after_reset", 1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hpdl1414_scan_driver.md
Name: hpdl1414_scan_driver

Overview:
Downstream consumer of the 16-entry display buffer. It periodically reads all 16 characters through the buffer's synchronous read port and writes each one into four HPDL-1414 displays (4 digits each) with correct setup, write-pulse and hold timing. It also generates the caret blink strobe that the buffer uses to substitute the caret character.

Parameters:
SETUP_CYCLES, 1, cycles addr/data are stable with wr_n high before the strobe (>=1)
WR_CYCLES, 2, cycles wr_n is held low (>=1; 166 ns at 12 MHz)
HOLD_CYCLES, 1, cycles addr/data are held after wr_n rises (>=1)
REFRESH_DIV, 120000, clock cycles between frame-start ticks (10 ms at 12 MHz)
BLINK_DIV, 3000000, clock cycles between caret strobe toggles (250 ms)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_enable  in  1  scanning permitted
o_read_enable  out  1  buffer read enable
o_read_address  out  4  buffer read address
i_read_data  in  8  buffer read data, valid the cycle after o_read_enable
o_caret_strobe  out  1  blink phase to the buffer (1 = show char, 0 = show caret)
o_hpdl_data  out  7  HPDL D6..D0
o_hpdl_addr  out  2  HPDL A1..A0 (digit select)
o_hpdl_wr_n  out  4  active-low write, one bit per display
o_frame_done  out  1  one-cycle pulse after the 16th character completes

Behaviour:
- Reset (async assert): state IDLE; o_hpdl_wr_n=4'hF; o_hpdl_data=0; o_hpdl_addr=0; o_read_enable=0; o_read_address=0; o_caret_strobe=1; o_frame_done=0; all counters 0; the pending flag is set to 1, so the first frame starts right after reset release when i_enable=1.
- Refresh counter: free-running, 0..REFRESH_DIV-1. At wrap it sets the pending flag. Ticks arriving while pending is already set merge into it and are not queued.
- Blink counter: free-running, 0..BLINK_DIV-1. At wrap it toggles o_caret_strobe. It is independent of the FSM.
- Index idx (4 bit) maps to display idx[3:2] and digit 3-idx[1:0], so buffer position 0 is the leftmost digit of display 0.
- FSM:
  - IDLE: when pending && i_enable, clear pending, set idx=0 and go to FETCH.
  - FETCH (1 cycle): o_read_enable=1, o_read_address=idx. Go to WAIT.
  - WAIT (1 cycle): o_read_enable=0. Register mapped(i_read_data) into o_hpdl_data and the digit into o_hpdl_addr. Go to SETUP.
  - SETUP: SETUP_CYCLES cycles with wr_n all high, then STROBE.
  - STROBE: o_hpdl_wr_n[idx[3:2]]=0 for exactly WR_CYCLES cycles; the other bits stay 1. Then HOLD.
  - HOLD: HOLD_CYCLES cycles with wr_n all high, data and addr unchanged.
  - After HOLD: if idx==15, pulse o_frame_done and go to IDLE. Else idx+1; go to FETCH if i_enable, otherwise IDLE (abandon the frame, leave pending unchanged).
- Per-character cost is 2+SETUP+WR+HOLD cycles. With defaults: 6 cycles per character, 96 cycles per frame.
- Character mapping (low 7 bits emitted):
  - 0x20..0x5F pass through.
  - 0x61..0x7A map to value-0x20 (upper case).
  - Everything else maps to 0x20.
- Invariants:
  - At most one wr_n bit is low at any time.
  - addr and data never change while any wr_n bit is low, or in the cycle wr_n rises.
- i_enable deassert mid-character: the character completes through HOLD.
- Reset mid-STROBE: wr_n returns to 4'hF immediately (asynchronous).
- Pending set during a frame: the next frame starts in the cycle after IDLE is re-entered.

Decomposition:
- Package hpdl_pkg holds:
  - FSM state enum (IDLE, FETCH, WAIT, SETUP, STROBE, HOLD)
  - DISPLAY_COUNT=4, DIGITS_PER_DISPLAY=4, BUFFER_DEPTH=16
  - CARETCHR=8'h5F, SPACECHR=8'h20, HPDL_MIN=8'h20, HPDL_MAX=8'h5F
- Sub-module hpdl_char_map is combinational, 8-bit in and 7-bit out. It is shared with any future serial/UART front end.

Test Plan:
- Reset held 5 cycles, then released with i_enable=1 → all outputs at reset values during reset. First o_read_enable appears within 2 cycles of release with address 0. Addresses 0..15 follow at 6-cycle spacing. o_frame_done pulses 96±1 cycles after the first fetch.
- Buffer model with mem[k]=0x41+k → the wr_n low sequence is bit0 ×4, bit1 ×4, bit2 ×4, bit3 ×4, each low exactly 2 cycles. For mem[5]=0x46, the strobe shows addr=2'd2 and data=0x46. Data and addr are stable from SETUP through HOLD.
- Mapping: mem values 0x61, 0x7A, 0x7F, 0x10, 0x5F → o_hpdl_data 0x41, 0x5A, 0x20, 0x20, 0x5F.
- BLINK_DIV=10, REFRESH_DIV=50 → o_caret_strobe toggles every 10 cycles starting at 1. The tick at cycle 50 lands mid-frame; the next frame starts the cycle after o_frame_done with no second queued frame.
- Assert i_rst during a STROBE cycle → o_hpdl_wr_n=4'hF in the same cycle, before the clock edge. After release, the frame restarts at address 0.
- Drop i_enable during SETUP of idx=3 → the character at idx 3 completes its strobe, no fetch of idx 4 occurs, and the FSM stays in IDLE. Re-asserting i_enable with pending set starts a new frame from idx 0.
